biu_master: RTL and testbench

- Bus Interface Unit, master side of the shared tri-state bus (address, data, control = {rnw, data_valid}); counterpart of the slave BIU.
- Takes single read/write requests from a local client, arbitrates for the bus, and drives one request cycle.
- For reads, waits for the slave's response beat, captures the data and returns it to the client. A timeout reports unanswered reads.

---
 rtl/biu_master.sv | 207 ++++++++++++++++++++
 tb/tb_biu_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_master.sv
// biu_master: master side of the shared tri-state bus.
// Accepts one read/write request from the local client, arbitrates for the
// bus, drives a single request beat and, for reads, waits for the matching
// response beat (or a timeout) before reporting completion to the client.
module biu_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  n_rst,
  inout  wire  [ADDR_WIDTH-1:0] bus_address,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  inout  wire  [1:0]            bus_control,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  input  logic                  biu_en,
  input  logic                  biu_rnw,
  input  logic [ADDR_WIDTH-1:0] biu_address,
  input  logic [DATA_WIDTH-1:0] biu_data_out,
  output logic [DATA_WIDTH-1:0] biu_data_in,
  output logic                  biu_data_valid,
  output logic                  biu_error,
  output logic                  biu_busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // One-hot state encoding
  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_ARB  = 5'b00010;
  localparam logic [4:0] ST_SEND = 5'b00100;
  localparam logic [4:0] ST_WAIT = 5'b01000;
  localparam logic [4:0] ST_DONE = 5'b10000;

  logic [4:0]            state_r;
  logic [4:0]            state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  rnw_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0] data_in_r;
  logic                  rsp_match_s;
  logic                  timeout_hit_s;

  // Registered output copies and their next values
  logic                  req_r,   req_nxt_s;
  logic                  drive_r, drive_nxt_s;
  logic                  busy_r,  busy_nxt_s;
  logic                  dv_r,    dv_nxt_s;
  logic                  err_r,   err_nxt_s;

  // The bus is only driven during the single request beat
  assign bus_address = drive_r ? addr_r  : {ADDR_WIDTH{1'bz}};
  assign bus_data    = drive_r ? wdata_r : {DATA_WIDTH{1'bz}};
  assign bus_control = drive_r ? {rnw_r, 1'b1} : 2'bzz;

  assign bus_req        = req_r;
  assign biu_busy       = busy_r;
  assign biu_data_valid = dv_r;
  assign biu_error      = err_r;
  assign biu_data_in    = data_in_r;

  // Response detection: valid read beat for our address; Z/X never counts as valid
  always_comb begin
    rsp_match_s = 1'b0;
    if ((bus_control[0] === 1'b1) && (bus_control[1] === 1'b1) &&
        (bus_address == addr_r)) begin
      rsp_match_s = 1'b1;
    end else begin
      rsp_match_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a response in the timeout cycle still wins
  always_comb begin
    state_nxt_s   = ST_IDLE;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (biu_en) begin
          state_nxt_s = ST_ARB;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (bus_gnt) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_SEND: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (!rnw_r) begin
          state_nxt_s = ST_DONE;
        end else if (rsp_match_s) begin
          state_nxt_s = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s   = ST_DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    req_nxt_s   = 1'b0;
    drive_nxt_s = 1'b0;
    busy_nxt_s  = 1'b0;
    dv_nxt_s    = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_ARB: begin
        req_nxt_s  = 1'b1;
        busy_nxt_s = 1'b1;
      end
      ST_SEND: begin
        req_nxt_s   = 1'b1;
        busy_nxt_s  = 1'b1;
        drive_nxt_s = 1'b1;
      end
      ST_WAIT: begin
        req_nxt_s  = 1'b1;
        busy_nxt_s = 1'b1;
      end
      ST_DONE: begin
        busy_nxt_s = 1'b1;
        dv_nxt_s   = 1'b1;
        err_nxt_s  = timeout_hit_s;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_r   <= 1'b0;
      drive_r <= 1'b0;
      busy_r  <= 1'b0;
      dv_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      req_r   <= req_nxt_s;
      drive_r <= drive_nxt_s;
      busy_r  <= busy_nxt_s;
      dv_r    <= dv_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Request latch, wait counter and read-data capture
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_r    <= {ADDR_WIDTH{1'b0}};
      wdata_r   <= {DATA_WIDTH{1'b0}};
      rnw_r     <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      data_in_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && biu_en) begin
        addr_r  <= biu_address;
        wdata_r <= biu_data_out;
        rnw_r   <= biu_rnw;
      end
      if (state_r == ST_SEND) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_WAIT) && rnw_r && !rsp_match_s &&
                   (cnt_r != CNT_LAST)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if ((state_r == ST_WAIT) && rnw_r && rsp_match_s) begin
        data_in_r <= bus_data;
      end
    end
  end

endmodule

// File: tb/tb_biu_master.sv
// Testbench for biu_master: randomized client traffic against a small bus
// slave model; expected completions come from a transaction-level model and
// are checked by an independent monitor through scoreboard queues.
module tb_biu_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        bus_gnt = 1'b0;
  logic        bus_req;
  logic        biu_en = 1'b0;
  logic        biu_rnw = 1'b0;
  logic [31:0] biu_address = 32'h0;
  logic [31:0] biu_data_out = 32'h0;
  logic [31:0] biu_data_in;
  logic        biu_data_valid;
  logic        biu_error;
  logic        biu_busy;
  wire  [31:0] bus_address;
  wire  [31:0] bus_data;
  wire  [1:0]  bus_control;

  // slave model drive
  logic        s_drv = 1'b0;
  logic [31:0] s_addr = 32'h0;
  logic [31:0] s_data = 32'h0;
  logic [1:0]  s_ctrl = 2'b00;
  logic        s_pend = 1'b0;
  int          s_wait = 0;
  logic [31:0] s_req_addr = 32'h0;
  logic        s_inj_done = 1'b0;
  logic [31:0] s_mem [16];
  logic [15:0] s_written = 16'h0;
  int          lat_cfg = 0;
  logic        inj_en = 1'b0;

  assign bus_address = s_drv ? s_addr : 32'hzzzz_zzzz;
  assign bus_data    = s_drv ? s_data : 32'hzzzz_zzzz;
  assign bus_control = s_drv ? s_ctrl : 2'bzz;

  typedef struct { logic [31:0] data; logic err; int done_cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic rnw; int cyc; } req_t;

  rsp_t sb_q[$];
  req_t req_q[$];
  rsp_t mon_e;
  req_t mon_r;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_data_in = 32'h0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  biu_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_rst(n_rst),
    .bus_address(bus_address), .bus_data(bus_data), .bus_control(bus_control),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .biu_en(biu_en), .biu_rnw(biu_rnw), .biu_address(biu_address),
    .biu_data_out(biu_data_out), .biu_data_in(biu_data_in),
    .biu_data_valid(biu_data_valid), .biu_error(biu_error), .biu_busy(biu_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {16'hC0DE, 12'h000, a[3:0]};
  endfunction

  // Slave at 0x10..0x1F: dv=0 beat after each request, read data lat_cfg cycles later
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s_drv      <= 1'b0;
      s_pend     <= 1'b0;
      s_wait     <= 0;
      s_inj_done <= 1'b0;
    end else begin
      s_drv <= 1'b0;
      if (s_pend) begin
        if (s_wait == 0) begin
          s_drv  <= 1'b1;
          s_addr <= s_req_addr;
          s_data <= s_written[s_req_addr[3:0]] ? s_mem[s_req_addr[3:0]]
                                               : {16'hC0DE, 12'h000, s_req_addr[3:0]};
          s_ctrl <= 2'b11;
          s_pend <= 1'b0;
        end else begin
          s_wait <= s_wait - 1;
          if (inj_en && !s_inj_done) begin
            s_drv      <= 1'b1;
            s_addr     <= 32'h44;
            s_data     <= 32'hBAD0_0044;
            s_ctrl     <= 2'b11;
            s_inj_done <= 1'b1;
          end
        end
      end else if ((bus_control[0] === 1'b1) && !s_drv) begin
        s_inj_done <= 1'b0;
        if (bus_address[31:4] == 28'h1) begin
          s_drv  <= 1'b1;
          s_addr <= bus_address;
          s_data <= 32'h0;
          if (bus_control[1] === 1'b1) begin
            s_ctrl     <= 2'b10;
            s_pend     <= 1'b1;
            s_wait     <= lat_cfg;
            s_req_addr <= bus_address;
          end else begin
            s_ctrl                      <= 2'b00;
            s_mem[bus_address[3:0]]     <= bus_data;
            s_written[bus_address[3:0]] <= 1'b1;
          end
        end
      end
    end
  end

  // Monitor: completions and master request beats against the scoreboards
  always @(negedge clk) begin
    if (n_rst) begin
      if (biu_data_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_completion", 64'(biu_data_valid), 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("data_in", 64'(biu_data_in), 64'(mon_e.data));
          check("error", 64'(biu_error), 64'(mon_e.err));
          check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
          check("bus_req_at_done", 64'(bus_req), 64'd0);
          check("busy_at_done", 64'(biu_busy), 64'd1);
          done_cnt++;
        end
      end else begin
        check("error_without_valid", 64'(biu_error), 64'd0);
      end
      if ((bus_control[0] === 1'b1) && !s_drv) begin
        if (req_q.size() == 0) begin
          check("unexpected_bus_beat", 64'(bus_control), 64'd0);
        end else begin
          mon_r = req_q.pop_front();
          check("beat_addr", 64'(bus_address), 64'(mon_r.addr));
          check("beat_data", 64'(bus_data), 64'(mon_r.data));
          check("beat_rnw", 64'(bus_control[1]), 64'(mon_r.rnw));
          check("beat_cycle", 64'(cyc), 64'(mon_r.cyc));
        end
      end
    end
  end

  // One client transaction: g = cycles with gnt low in ARB, lat = slave latency
  task automatic run_txn(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                         input int g, input int lat, input logic inj, input logic dup);
    rsp_t e;
    req_t r;
    int   c;
    int   start_done;
    int   limit;
    logic mapped;
    c = cyc;
    mapped = (addr >= 32'h10) && (addr <= 32'h1F);
    e.err = 1'b0;
    if (!rnw) begin
      if (mapped) ref_mem[addr] = wdata;
      e.data = ref_data_in;
      e.done_cyc = c + 4 + g;
    end else if (mapped && (lat + 2 <= TMO)) begin
      ref_data_in = ref_read(addr);
      e.data = ref_data_in;
      e.done_cyc = c + 3 + g + lat + 2;
    end else begin
      e.err = 1'b1;
      e.data = ref_data_in;
      e.done_cyc = c + 3 + g + TMO;
    end
    r.addr = addr; r.data = wdata; r.rnw = rnw; r.cyc = c + 2 + g;
    sb_q.push_back(e);
    req_q.push_back(r);
    lat_cfg = lat;
    inj_en = inj;
    biu_en = 1'b1; biu_rnw = rnw; biu_address = addr; biu_data_out = wdata;
    bus_gnt = (g == 0);
    start_done = done_cnt;
    limit = 0;
    while ((done_cnt == start_done) && (limit < 200)) begin
      @(posedge clk); #1;
      limit++;
      if (cyc == c + 1) begin
        biu_en = 1'b0; biu_rnw = 1'($urandom);
        biu_address = $urandom; biu_data_out = $urandom;
      end
      if (cyc == c + 1 + g) bus_gnt = 1'b1;
      if (dup && (cyc == c + 3)) begin
        biu_en = 1'b1; biu_address = addr ^ 32'h1; biu_rnw = ~rnw;
      end else if (cyc == c + 4) begin
        biu_en = 1'b0;
      end
      if ((done_cnt == start_done) && (cyc < e.done_cyc)) begin
        check("bus_req_held", 64'(bus_req), 64'd1);
        check("busy_held", 64'(biu_busy), 64'd1);
      end
    end
    biu_en = 1'b0;
    check("completion_seen", 64'(done_cnt != start_done), 64'd1);
    if (done_cnt == start_done) begin
      n_rst = 1'b0; #1;
      sb_q.delete(); req_q.delete(); ref_data_in = 32'h0;
      @(posedge clk); #1;
      n_rst = 1'b1;
    end else begin
      check("idle_busy", 64'(biu_busy), 64'd0);
      check("idle_bus_req", 64'(bus_req), 64'd0);
    end
  endtask

  logic        t_rnw;
  logic [31:0] t_addr;
  int          t_g;
  int          t_lat;
  logic        t_inj;
  logic        t_dup;
  int          t_c;
  req_t        t_r;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_in", 64'(biu_data_in), 64'd0);
    check("rst_data_valid", 64'(biu_data_valid), 64'd0);
    check("rst_error", 64'(biu_error), 64'd0);
    check("rst_busy", 64'(biu_busy), 64'd0);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_bus_released", 64'(bus_control[0] === 1'b1), 64'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 32'h10, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 32'h10, 32'h0000_0001, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h10, 32'h12345678, 0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 32'h10, 32'h0000_0002, 0, 3, 1'b0, 1'b0);
    run_txn(1'b1, 32'h40, 32'h0000_0003, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h11, 32'hCAFE_F00D, 10, 0, 1'b0, 1'b0);
    run_txn(1'b1, 32'h10, 32'h0000_0004, 0, 3, 1'b1, 1'b0);
    run_txn(1'b1, 32'h13, 32'h0000_0005, 0, 6, 1'b0, 1'b0);
    run_txn(1'b1, 32'h13, 32'h0000_0006, 0, 7, 1'b0, 1'b0);

    // Reset in the middle of a read: no completion may follow
    t_c = cyc;
    t_r.addr = 32'h12; t_r.data = 32'h5555_AAAA; t_r.rnw = 1'b1; t_r.cyc = t_c + 2;
    req_q.push_back(t_r);
    lat_cfg = 5; inj_en = 1'b0;
    biu_en = 1'b1; biu_rnw = 1'b1; biu_address = 32'h12; biu_data_out = 32'h5555_AAAA;
    bus_gnt = 1'b1;
    while (cyc < t_c + 5) begin
      @(posedge clk); #1;
      biu_en = 1'b0;
    end
    check("pre_reset_busy", 64'(biu_busy), 64'd1);
    n_rst = 1'b0;
    #1;
    check("abort_busy", 64'(biu_busy), 64'd0);
    check("abort_bus_req", 64'(bus_req), 64'd0);
    check("abort_data_valid", 64'(biu_data_valid), 64'd0);
    check("abort_data_in", 64'(biu_data_in), 64'd0);
    check("abort_bus_released", 64'(bus_control[0] === 1'b1), 64'd0);
    ref_data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 32'h15, 32'h0000_0007, 1, 2, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      t_rnw  = 1'($urandom_range(1, 0));
      t_addr = ($urandom_range(9, 0) == 0) ? (32'h40 + 32'($urandom_range(15, 0)))
                                           : (32'h10 + 32'($urandom_range(15, 0)));
      t_g    = int'($urandom_range(3, 0));
      t_lat  = int'($urandom_range(7, 0));
      t_inj  = t_rnw && (t_lat >= 1) && ($urandom_range(1, 0) == 1);
      t_dup  = ($urandom_range(3, 0) == 0);
      run_txn(t_rnw, t_addr, $urandom, t_g, t_lat, t_inj, t_dup);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("request_queue_drained", 64'(req_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
